// File: rtl/vga_pixel_unpack_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_unpack_if
//  Description : Bundle of the FIFO read side, the pixel request/response
//                path and the underflow statistics of vga_pixel_unpack.
//                The slave modport is the unpacker; the master modport is
//                its environment (FIFO owner, timing generator, CSR read).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_pixel_unpack_if #(
  parameter int CNT_W = 16
);

  // FIFO read side
  logic             data_fifo_empty;
  logic [127:0]     ddr_fifo_rd_data;
  logic             vga_rd_valid;

  // Timing generator side
  logic             pixel_req;
  logic             frame_start;
  logic [7:0]       pix_r;
  logic [7:0]       pix_g;
  logic [7:0]       pix_b;
  logic             pix_valid;

  // Per-frame statistics
  logic             underflow;
  logic [CNT_W-1:0] underflow_cnt;

  modport slave (
    input  data_fifo_empty,
    input  ddr_fifo_rd_data,
    output vga_rd_valid,
    input  pixel_req,
    input  frame_start,
    output pix_r,
    output pix_g,
    output pix_b,
    output pix_valid,
    output underflow,
    output underflow_cnt
  );

  modport master (
    output data_fifo_empty,
    output ddr_fifo_rd_data,
    input  vga_rd_valid,
    output pixel_req,
    output frame_start,
    input  pix_r,
    input  pix_g,
    input  pix_b,
    input  pix_valid,
    input  underflow,
    input  underflow_cnt
  );

endinterface
`default_nettype wire

// File: rtl/vga_pixel_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_unpack
//  Description : Unpacks 128-bit DDR3 read words (4 x 32-bit RGB lanes,
//                lane 0 first) into one 24-bit pixel per requested cycle.
//                Keeps a 2-word buffer, issues FIFO reads only when a slot
//                is guaranteed, substitutes UNDERFLOW_RGB when starved and
//                counts starved pixels per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_unpack #(
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF,
  parameter int          CNT_W         = 16
) (
  input  logic              vga_clk,
  input  logic              vga_reset,
  vga_pixel_unpack_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Buffered words keep only the 24 colour bits of each lane (96 bits).
  logic [95:0]      word_q [2];
  logic [95:0]      word_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;        // buffered words, 0..2
  logic [1:0]       lane_q, lane_d;      // next lane of the head word
  logic             inflight_q, inflight_d;

  logic [23:0]      pix_rgb_q, pix_rgb_d;
  logic             pix_valid_q, pix_valid_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] underflow_cnt_q, underflow_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [2:0]       committed;           // buffered words plus word on the bus
  logic             rd_strobe;
  logic [95:0]      word_in;
  logic [95:0]      head_word;
  logic [23:0]      lane_rgb;
  logic             have_pixel;
  logic             pix_take;
  logic             pix_starve;
  logic             head_pop;

  // The top byte of every lane carries no colour information.
  logic             unused_lane_msbs;
  assign unused_lane_msbs = ^{bus.ddr_fifo_rd_data[127:120],
                              bus.ddr_fifo_rd_data[95:88],
                              bus.ddr_fifo_rd_data[63:56],
                              bus.ddr_fifo_rd_data[31:24]};

  // Read issue: a pop is only requested when a buffer slot is already
  // reserved for it, counting the word still travelling on the bus.
  always_comb begin
    committed = {1'b0, occ_q} + {2'b00, inflight_q};
    rd_strobe = !vga_reset && !bus.data_fifo_empty && (committed < 3'd2);
  end

  // Strip the unused lane bytes and select the current lane of the head word.
  always_comb begin
    word_in   = {bus.ddr_fifo_rd_data[119:96], bus.ddr_fifo_rd_data[87:64],
                 bus.ddr_fifo_rd_data[55:32],  bus.ddr_fifo_rd_data[23:0]};
    head_word = word_q[head_q];
    case (lane_q)
      2'd0:    lane_rgb = head_word[23:0];
      2'd1:    lane_rgb = head_word[47:24];
      2'd2:    lane_rgb = head_word[71:48];
      default: lane_rgb = head_word[95:72];
    endcase
  end

  // Capture the word returned for last cycle's strobe into the tail slot.
  always_comb begin
    word_d[0]  = word_q[0];
    word_d[1]  = word_q[1];
    tail_d     = tail_q;
    inflight_d = rd_strobe;
    if (inflight_q) begin
      word_d[tail_q] = word_in;
      tail_d         = ~tail_q;
    end
  end

  // Pixel output, lane advance and head pop. A word captured this cycle is
  // not visible yet, so an empty buffer always yields the underflow colour.
  always_comb begin
    have_pixel  = (occ_q != 2'd0);
    pix_take    = bus.pixel_req && have_pixel;
    pix_starve  = bus.pixel_req && !have_pixel;
    head_pop    = pix_take && (lane_q == 2'd3);

    lane_d      = lane_q;
    head_d      = head_q;
    pix_rgb_d   = 24'h000000;
    pix_valid_d = bus.pixel_req;

    if (pix_take) begin
      pix_rgb_d = lane_rgb;
      lane_d    = lane_q + 2'd1;           // 3 wraps to 0 with the pop
      if (head_pop) begin
        head_d = ~head_q;
      end
    end else if (pix_starve) begin
      pix_rgb_d = UNDERFLOW_RGB;
    end
  end

  // Occupancy: a capture and a pop in the same cycle cancel out.
  always_comb begin
    occ_d = occ_q;
    case ({inflight_q, head_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Underflow statistics; an underflow coincident with frame_start belongs
  // to the new frame.
  always_comb begin
    underflow_d     = underflow_q;
    underflow_cnt_d = underflow_cnt_q;
    if (bus.frame_start) begin
      underflow_d     = pix_starve;
      underflow_cnt_d = pix_starve ? CNT_ONE : '0;
    end else if (pix_starve) begin
      underflow_d = 1'b1;
      if (underflow_cnt_q != CNT_MAX) begin
        underflow_cnt_d = underflow_cnt_q + CNT_ONE;
      end
    end
  end

  // State register with synchronous reset; a word arriving during reset
  // is dropped because inflight is cleared.
  always_ff @(posedge vga_clk) begin
    if (vga_reset) begin
      word_q[0]       <= '0;
      word_q[1]       <= '0;
      head_q          <= 1'b0;
      tail_q          <= 1'b0;
      occ_q           <= 2'd0;
      lane_q          <= 2'd0;
      inflight_q      <= 1'b0;
      pix_rgb_q       <= 24'h000000;
      pix_valid_q     <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      word_q[0]       <= word_d[0];
      word_q[1]       <= word_d[1];
      head_q          <= head_d;
      tail_q          <= tail_d;
      occ_q           <= occ_d;
      lane_q          <= lane_d;
      inflight_q      <= inflight_d;
      pix_rgb_q       <= pix_rgb_d;
      pix_valid_q     <= pix_valid_d;
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.vga_rd_valid  = rd_strobe;
  assign bus.pix_r         = pix_rgb_q[23:16];
  assign bus.pix_g         = pix_rgb_q[15:8];
  assign bus.pix_b         = pix_rgb_q[7:0];
  assign bus.pix_valid     = pix_valid_q;
  assign bus.underflow     = underflow_q;
  assign bus.underflow_cnt = underflow_cnt_q;

endmodule
`default_nettype wire
